// File: rtl/sram_bus_arbiter.sv
// Two-requester (IF / MEM) arbiter onto one SRAM-like master bus, one transaction in flight.
// Latches and kseg-translates the granted request, then steers the slave response back to its owner.
module sram_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_uncached,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t             r_state;
  logic               r_owner_mem;
  logic               r_wr;
  logic [1:0]         r_size;
  logic [31:0]        r_paddr;
  logic [31:0]        r_wdata;
  logic               r_uncached;
  logic [CNT_W-1:0]   r_starve_cnt;

  logic               w_idle;
  logic               w_starved;
  logic               w_grant_mem;
  logic               w_grant_if;
  logic               w_resp_ok;
  logic               w_gnt_wr;
  logic [1:0]         w_gnt_size;
  logic [31:0]        w_gnt_vaddr;
  logic [31:0]        w_gnt_wdata;

  function automatic logic [31:0] kseg_xlate(input logic [31:0] va);
    if (va[31:30] == 2'b10) return {3'b000, va[28:0]};
    return va;
  endfunction

  // IF overrides MEM only once it has lost STARVE_LIMIT arbitrations in a row
  assign w_idle      = resetn && (r_state == S_IDLE);
  assign w_starved   = inst_req && (r_starve_cnt >= CNT_W'(STARVE_LIMIT));
  assign w_grant_mem = w_idle && data_req && !w_starved;
  assign w_grant_if  = w_idle && inst_req && !w_grant_mem;

  assign w_gnt_wr    = w_grant_mem ? data_wr    : inst_wr;
  assign w_gnt_size  = w_grant_mem ? data_size  : inst_size;
  assign w_gnt_vaddr = w_grant_mem ? data_addr  : inst_addr;
  assign w_gnt_wdata = w_grant_mem ? data_wdata : inst_wdata;

  assign inst_addr_ok = w_grant_if;
  assign data_addr_ok = w_grant_mem;

  assign w_resp_ok    = resetn && (r_state == S_RESP) && m_data_ok;
  assign inst_data_ok = w_resp_ok && !r_owner_mem;
  assign data_data_ok = w_resp_ok &&  r_owner_mem;
  assign inst_rdata   = inst_data_ok ? m_rdata : 32'h0;
  assign data_rdata   = data_data_ok ? m_rdata : 32'h0;

  assign m_req      = (r_state == S_REQ);
  assign m_wr       = r_wr;
  assign m_size     = r_size;
  assign m_addr     = r_paddr;
  assign m_wdata    = r_wdata;
  assign m_uncached = r_uncached;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_owner_mem  <= 1'b0;
      r_wr         <= 1'b0;
      r_size       <= 2'b00;
      r_paddr      <= 32'h0;
      r_wdata      <= 32'h0;
      r_uncached   <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_mem || w_grant_if) begin
            r_state     <= S_REQ;
            r_owner_mem <= w_grant_mem;
            r_wr        <= w_gnt_wr;
            r_size      <= w_gnt_size;
            r_paddr     <= kseg_xlate(w_gnt_vaddr);
            r_wdata     <= w_gnt_wdata;
            r_uncached  <= (w_gnt_vaddr[31:29] == 3'b101);
          end
          if (w_grant_mem && inst_req) begin
            if (r_starve_cnt != {CNT_W{1'b1}}) r_starve_cnt <= r_starve_cnt + 1'b1;
          end else if (w_grant_if || !inst_req) begin
            r_starve_cnt <= '0;
          end
        end
        S_REQ: begin
          if (m_addr_ok) r_state <= S_RESP;
        end
        S_RESP: begin
          if (m_data_ok) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: the slave side is driven by hand, one cycle at a time.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        m_req, m_wr, m_uncached;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_uncached(m_uncached),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks sample 2 units later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #2;
  endtask

  // Called in REQ: immediate slave accepts, returns rd next cycle; checks routing.
  task automatic serve(input logic exp_mem, input logic [31:0] rd);
    m_addr_ok = 1'b1;
    tick();
    m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = rd;
    settle();
    check("resp_m_req_low", {31'h0, m_req}, 32'h0);
    check("resp_data_ok", {31'h0, data_data_ok}, {31'h0, exp_mem});
    check("resp_inst_ok", {31'h0, inst_data_ok}, {31'h0, !exp_mem});
    check("resp_data_rdata", data_rdata, exp_mem ? rd : 32'h0);
    check("resp_inst_rdata", inst_rdata, exp_mem ? 32'h0 : rd);
    tick();
    m_data_ok = 1'b0; m_rdata = 32'h0;
  endtask

  // Called in IDLE with requests already driven; checks the winner and runs the transaction.
  task automatic arb(input string tag, input logic exp_mem, input logic [31:0] rd);
    settle();
    check({tag, "_data_addr_ok"}, {31'h0, data_addr_ok}, {31'h0, exp_mem});
    check({tag, "_inst_addr_ok"}, {31'h0, inst_addr_ok}, {31'h0, !exp_mem});
    tick();
    serve(exp_mem, rd);
  endtask

  initial begin
    resetn = 1'b0;
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    tick(); tick();
    settle();
    check("rst_m_req", {31'h0, m_req}, 32'h0);
    check("rst_m_addr", m_addr, 32'h0);
    check("rst_m_wdata", m_wdata, 32'h0);
    check("rst_flags", {26'h0, m_wr, m_size, m_uncached, inst_addr_ok, data_addr_ok}, 32'h0);
    check("rst_resp", {30'h0, inst_data_ok, data_data_ok}, 32'h0);
    resetn = 1'b1;
    tick();

    // Single IF read from kseg1 boot vector
    inst_req = 1; inst_addr = 32'hBFC0_0000;
    settle();
    check("if1_addr_ok", {31'h0, inst_addr_ok}, 32'h1);
    check("if1_mem_addr_ok", {31'h0, data_addr_ok}, 32'h0);
    tick();
    inst_req = 0; inst_addr = 32'h0;
    settle();
    check("if1_m_req", {31'h0, m_req}, 32'h1);
    check("if1_m_addr", m_addr, 32'h1FC0_0000);
    check("if1_m_uncached", {31'h0, m_uncached}, 32'h1);
    check("if1_m_wr", {31'h0, m_wr}, 32'h0);
    serve(1'b0, 32'h3C08_0001);
    settle();
    check("if1_idle_inst_ok", {31'h0, inst_data_ok}, 32'h0);
    check("if1_idle_rdata", inst_rdata, 32'h0);

    // Simultaneous: MEM write to kseg0 wins, IF follows
    inst_req = 1; inst_addr = 32'hBFC0_0004;
    data_req = 1; data_wr = 1; data_addr = 32'h8000_1000; data_wdata = 32'hDEAD_BEEF;
    settle();
    check("sim_data_addr_ok", {31'h0, data_addr_ok}, 32'h1);
    check("sim_inst_addr_ok", {31'h0, inst_addr_ok}, 32'h0);
    tick();
    data_req = 0; data_wr = 0;
    settle();
    check("sim_m_addr", m_addr, 32'h0000_1000);
    check("sim_m_wr", {31'h0, m_wr}, 32'h1);
    check("sim_m_uncached", {31'h0, m_uncached}, 32'h0);
    check("sim_m_wdata", m_wdata, 32'hDEAD_BEEF);
    check("sim_inst_wait", {31'h0, inst_addr_ok}, 32'h0);
    serve(1'b1, 32'h0000_0011);
    arb("sim_if", 1'b0, 32'h0000_0022);
    inst_req = 0;
    tick();

    // Starvation: both request continuously
    inst_req = 1; inst_addr = 32'h0000_0100;
    data_req = 1; data_addr = 32'h0000_0200;
    arb("stv1", 1'b1, 32'h1);
    arb("stv2", 1'b1, 32'h2);
    arb("stv3", 1'b1, 32'h3);
    arb("stv4", 1'b1, 32'h4);
    arb("stv5", 1'b0, 32'h5);
    arb("stv6", 1'b1, 32'h6);
    inst_req = 0; data_req = 0;
    tick();

    // Slow slave: addr_ok delayed 3 cycles, IF waiting
    data_req = 1; data_wr = 1; data_addr = 32'hA000_0010; data_wdata = 32'hCAFE_F00D;
    inst_req = 1; inst_addr = 32'h0040_0000;
    settle();
    check("slow_data_addr_ok", {31'h0, data_addr_ok}, 32'h1);
    tick();
    data_req = 0; data_wr = 0; data_addr = 32'h1234_5678; data_wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("slow_m_req", {31'h0, m_req}, 32'h1);
      check("slow_m_addr", m_addr, 32'h0000_0010);
      check("slow_m_wdata", m_wdata, 32'hCAFE_F00D);
      check("slow_m_uncached", {31'h0, m_uncached}, 32'h1);
      check("slow_no_grant", {30'h0, inst_addr_ok, data_addr_ok}, 32'h0);
      tick();
    end
    serve(1'b1, 32'h0000_0033);

    // kuseg and kseg2 pass through untranslated
    settle();
    check("kuseg_addr_ok", {31'h0, inst_addr_ok}, 32'h1);
    tick();
    inst_req = 0;
    settle();
    check("kuseg_m_addr", m_addr, 32'h0040_0000);
    check("kuseg_uncached", {31'h0, m_uncached}, 32'h0);
    serve(1'b0, 32'h0000_0044);
    inst_req = 1; inst_addr = 32'hC000_0000;
    settle();
    check("kseg2_addr_ok", {31'h0, inst_addr_ok}, 32'h1);
    tick();
    inst_req = 0;
    settle();
    check("kseg2_m_addr", m_addr, 32'hC000_0000);
    check("kseg2_uncached", {31'h0, m_uncached}, 32'h0);

    // Reset while in RESP abandons the transaction
    m_addr_ok = 1;
    tick();
    m_addr_ok = 0;
    resetn = 0; inst_req = 1; inst_addr = 32'h0000_0300;
    settle();
    check("rst_addr_ok_forced", {30'h0, inst_addr_ok, data_addr_ok}, 32'h0);
    tick();
    resetn = 1; inst_req = 0;
    settle();
    check("rstresp_m_req", {31'h0, m_req}, 32'h0);
    check("rstresp_m_addr", m_addr, 32'h0);
    m_data_ok = 1; m_rdata = 32'h5555_5555;
    settle();
    check("rstresp_no_data_ok", {30'h0, inst_data_ok, data_data_ok}, 32'h0);
    check("rstresp_rdata", inst_rdata | data_rdata, 32'h0);
    tick();
    m_data_ok = 0; m_rdata = 0;
    data_req = 1; data_addr = 32'h8000_0020;
    settle();
    check("post_rst_addr_ok", {31'h0, data_addr_ok}, 32'h1);
    tick();
    data_req = 0;
    settle();
    check("post_rst_m_addr", m_addr, 32'h0000_0020);
    check("post_rst_m_wr", {31'h0, m_wr}, 32'h0);
    serve(1'b1, 32'h0000_0066);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
